// File: rtl/ex_muldiv_sequencer_pkg.sv
// Shared definitions for the EX-stage multiply/divide sequencer: funct codes,
// FSM state encoding and small funct-decode helpers.
package ex_muldiv_sequencer_pkg;

    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    function automatic logic funct_legal(input logic [5:0] f);
        return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
               (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
    endfunction

    function automatic logic funct_is_div(input logic [5:0] f);
        return (f == FUNCT_DIV) || (f == FUNCT_DIVU);
    endfunction

    function automatic logic funct_is_signed(input logic [5:0] f);
        return (f == FUNCT_MULT) || (f == FUNCT_DIV);
    endfunction

endpackage

// File: rtl/ex_muldiv_sequencer_if.sv
// Request/HI-LO bus between the ID/EX latch side and the multiply/divide sequencer.
interface ex_muldiv_sequencer_if #(
    parameter int NB_DATA  = 32,
    parameter int NB_FUNCT = 6
);
    logic                i_start;
    logic [NB_FUNCT-1:0] i_funct;
    logic [NB_DATA-1:0]  i_operand_a;
    logic [NB_DATA-1:0]  i_operand_b;
    logic                i_flush;
    logic                i_hi_we;
    logic                i_lo_we;
    logic [NB_DATA-1:0]  i_wdata;
    logic                o_busy;
    logic                o_done;
    logic [NB_DATA-1:0]  o_hi;
    logic [NB_DATA-1:0]  o_lo;

    modport master (
        output i_start, i_funct, i_operand_a, i_operand_b,
        output i_flush, i_hi_we, i_lo_we, i_wdata,
        input  o_busy, o_done, o_hi, o_lo
    );

    modport slave (
        input  i_start, i_funct, i_operand_a, i_operand_b,
        input  i_flush, i_hi_we, i_lo_we, i_wdata,
        output o_busy, o_done, o_hi, o_lo
    );
endinterface

// File: rtl/ex_muldiv_sequencer_core.sv
// Unsigned radix-2 datapath: shift-add multiplier / restoring divider,
// one step per enabled cycle on magnitudes prepared by the sequencer.
module ex_muldiv_sequencer_core #(
    parameter int NB_DATA = 32
) (
    input  logic               clk,
    input  logic               load,
    input  logic               step,
    input  logic               is_div,
    input  logic [NB_DATA-1:0] a,
    input  logic [NB_DATA-1:0] b,
    output logic [NB_DATA-1:0] hi_res,
    output logic [NB_DATA-1:0] lo_res
);

    // acc_hi: partial product / partial remainder; acc_lo: multiplier / quotient bits
    logic [NB_DATA-1:0] acc_hi;
    logic [NB_DATA-1:0] acc_lo;
    logic [NB_DATA-1:0] opnd_b;

    logic [NB_DATA:0]   mul_sum;
    logic [NB_DATA:0]   div_shift;
    logic [NB_DATA:0]   div_trial;

    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : '0);
        div_shift = {acc_hi, acc_lo[NB_DATA-1]};
        // Partial remainder stays below the divisor, so the top bit is a clean borrow
        div_trial = div_shift - {1'b0, opnd_b};
    end

    always_ff @(posedge clk) begin
        if (load) begin
            acc_hi <= '0;
            acc_lo <= a;
            opnd_b <= b;
        end else if (step) begin
            if (is_div) begin
                if (!div_trial[NB_DATA]) begin
                    acc_hi <= div_trial[NB_DATA-1:0];
                    acc_lo <= {acc_lo[NB_DATA-2:0], 1'b1};
                end else begin
                    acc_hi <= div_shift[NB_DATA-1:0];
                    acc_lo <= {acc_lo[NB_DATA-2:0], 1'b0};
                end
            end else begin
                acc_hi <= mul_sum[NB_DATA:1];
                acc_lo <= {mul_sum[0], acc_lo[NB_DATA-1:1]};
            end
        end
    end

    assign hi_res = acc_hi;
    assign lo_res = acc_lo;

endmodule

// File: rtl/ex_muldiv_sequencer.sv
// EX-stage iterative MULT/MULTU/DIV/DIVU sequencer with the HI/LO register file
// and MTHI/MTLO write port.
module ex_muldiv_sequencer
    import ex_muldiv_sequencer_pkg::*;
#(
    parameter int NB_DATA  = 32,
    parameter int NB_FUNCT = 6,
    parameter int NB_COUNT = 6
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    ex_muldiv_sequencer_if.slave  bus
);

    function automatic logic [NB_DATA-1:0] magnitude(
        input logic signed [NB_DATA-1:0] v,
        input logic                      use_sign
    );
        logic signed [NB_DATA-1:0] r;
        r = (use_sign && v[NB_DATA-1]) ? -v : v;
        return r;
    endfunction

    function automatic logic [NB_DATA-1:0] cond_neg(
        input logic signed [NB_DATA-1:0] v,
        input logic                      neg
    );
        logic signed [NB_DATA-1:0] r;
        r = neg ? -v : v;
        return r;
    endfunction

    function automatic logic [2*NB_DATA-1:0] cond_neg_wide(
        input logic signed [2*NB_DATA-1:0] v,
        input logic                        neg
    );
        logic signed [2*NB_DATA-1:0] r;
        r = neg ? -v : v;
        return r;
    endfunction

    state_t                state;
    logic [NB_COUNT-1:0]   count;
    logic                  busy_q;
    logic                  done_q;
    logic [NB_DATA-1:0]    hi_q;
    logic [NB_DATA-1:0]    lo_q;
    logic                  is_div_q;
    logic                  sgn_a_q;
    logic                  sgn_b_q;
    logic                  div_zero_q;

    logic [NB_FUNCT-1:0]   funct_in;
    logic [5:0]            funct;
    logic                  op_signed;
    logic                  sgn_a;
    logic                  sgn_b;
    logic                  accept;
    logic [NB_DATA-1:0]    mag_a;
    logic [NB_DATA-1:0]    mag_b;
    logic [NB_DATA-1:0]    core_hi;
    logic [NB_DATA-1:0]    core_lo;
    logic [2*NB_DATA-1:0]  prod_fix;
    logic [NB_DATA-1:0]    quot_fix;
    logic [NB_DATA-1:0]    rem_fix;

    assign funct_in  = bus.i_funct;
    assign funct     = 6'(funct_in);
    assign op_signed = funct_is_signed(funct);
    assign sgn_a     = op_signed & bus.i_operand_a[NB_DATA-1];
    assign sgn_b     = op_signed & bus.i_operand_b[NB_DATA-1];
    assign mag_a     = magnitude(bus.i_operand_a, op_signed);
    assign mag_b     = magnitude(bus.i_operand_b, op_signed);
    // Flush squashes a request presented in the same IDLE cycle
    assign accept    = (state == ST_IDLE) && bus.i_start && !bus.i_flush && funct_legal(funct);

    ex_muldiv_sequencer_core #(.NB_DATA(NB_DATA)) u_core (
        .clk    (i_clk),
        .load   (accept),
        .step   (state == ST_RUN),
        .is_div (is_div_q),
        .a      (mag_a),
        .b      (mag_b),
        .hi_res (core_hi),
        .lo_res (core_lo)
    );

    // Sign correction; most-negative / -1 wraps back to itself, giving the expected overflow result
    always_comb begin
        prod_fix = cond_neg_wide({core_hi, core_lo}, sgn_a_q ^ sgn_b_q);
        quot_fix = div_zero_q ? '1 : cond_neg(core_lo, sgn_a_q ^ sgn_b_q);
        rem_fix  = cond_neg(core_hi, sgn_a_q);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= ST_IDLE;
            count      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            is_div_q   <= 1'b0;
            sgn_a_q    <= 1'b0;
            sgn_b_q    <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.i_hi_we) hi_q <= bus.i_wdata;
                    if (bus.i_lo_we) lo_q <= bus.i_wdata;
                    if (accept) begin
                        state      <= ST_RUN;
                        busy_q     <= 1'b1;
                        count      <= '0;
                        is_div_q   <= funct_is_div(funct);
                        sgn_a_q    <= sgn_a;
                        sgn_b_q    <= sgn_b;
                        div_zero_q <= (bus.i_operand_b == '0);
                    end
                end
                ST_RUN: begin
                    if (bus.i_flush) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        count <= count + 1'b1;
                        if (count == NB_COUNT'(NB_DATA - 1)) state <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                    if (!bus.i_flush) begin
                        done_q <= 1'b1;
                        if (is_div_q) begin
                            hi_q <= rem_fix;
                            lo_q <= quot_fix;
                        end else begin
                            hi_q <= prod_fix[2*NB_DATA-1:NB_DATA];
                            lo_q <= prod_fix[NB_DATA-1:0];
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_busy = busy_q;
    assign bus.o_done = done_q;
    assign bus.o_hi   = hi_q;
    assign bus.o_lo   = lo_q;

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Directed bench for ex_muldiv_sequencer: arithmetic reference model checked
// every cycle plus literal expectations for the key cases.
module tb_ex_muldiv_sequencer;

    localparam int N = 32;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    bit   chk_en = 1'b0;

    ex_muldiv_sequencer_if #(.NB_DATA(N), .NB_FUNCT(6)) bus ();

    ex_muldiv_sequencer #(.NB_DATA(N), .NB_FUNCT(6), .NB_COUNT(6)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference results straight from the arithmetic definition
    function automatic void compute(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] hi, output logic [31:0] lo);
        logic signed [63:0] sp;
        logic [63:0] up;
        hi = '0;
        lo = '0;
        case (f)
            F_MULT: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                {hi, lo} = sp;
            end
            F_MULTU: begin
                up = {32'b0, a} * {32'b0, b};
                {hi, lo} = up;
            end
            F_DIV: begin
                if (b == 0) begin
                    lo = '1; hi = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo = 32'h8000_0000; hi = 0;
                end else begin
                    lo = $signed(a) / $signed(b);
                    hi = $signed(a) % $signed(b);
                end
            end
            default: begin
                if (b == 0) begin
                    lo = '1; hi = a;
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
        endcase
    endfunction

    logic        m_busy, m_done;
    logic [31:0] m_hi, m_lo, m_res_hi, m_res_lo;
    int          m_cnt;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_done = 0; m_hi = 0; m_lo = 0; m_cnt = 0;
        end else begin
            m_done = 0;
            if (!m_busy) begin
                if (bus.i_hi_we) m_hi = bus.i_wdata;
                if (bus.i_lo_we) m_lo = bus.i_wdata;
                if (bus.i_start && !bus.i_flush &&
                    (bus.i_funct inside {F_MULT, F_MULTU, F_DIV, F_DIVU})) begin
                    m_busy = 1;
                    m_cnt  = N + 1;
                    compute(bus.i_funct, bus.i_operand_a, bus.i_operand_b, m_res_hi, m_res_lo);
                end
            end else if (bus.i_flush) begin
                m_busy = 0;
            end else begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_hi = m_res_hi; m_lo = m_res_lo; m_done = 1; m_busy = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy", bus.o_busy, m_busy);
            check("cyc_done", bus.o_done, m_done);
            check("cyc_hi",   bus.o_hi,   m_hi);
            check("cyc_lo",   bus.o_lo,   m_lo);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        bus.i_start = 1; bus.i_funct = f; bus.i_operand_a = a; bus.i_operand_b = b;
    endtask

    task automatic clear_req();
        bus.i_start = 0; bus.i_flush = 0; bus.i_hi_we = 0; bus.i_lo_we = 0;
    endtask

    task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        present(f, a, b);
        tick();
        clear_req();
        repeat (N + 1) tick();
        check({name, "_done"}, bus.o_done, 1'b1);
        check({name, "_hi"},   bus.o_hi,   exp_hi);
        check({name, "_lo"},   bus.o_lo,   exp_lo);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_req();
        bus.i_funct = '0; bus.i_operand_a = '0; bus.i_operand_b = '0; bus.i_wdata = '0;
        tick();
        chk_en = 1;
        tick();
        rst = 0;
        check("rst_busy", bus.o_busy, 1'b0);
        check("rst_done", bus.o_done, 1'b0);
        check("rst_hi",   bus.o_hi,   32'h0);
        check("rst_lo",   bus.o_lo,   32'h0);

        run_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_neg",  F_MULT,  32'hFFFF_FFF1, 32'd10,        32'hFFFF_FFFF, 32'hFFFF_FF6A);
        run_op("div_neg",   F_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_zero", F_DIVU,  32'h10,        32'h0,         32'h0000_0010, 32'hFFFF_FFFF);
        run_op("div_ovf",   F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000);
        run_op("div_zero_s",F_DIV,   32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run_op("divu_rem",  F_DIVU,  32'd100,       32'd7,         32'd2,         32'd14);
        run_op("mult_min",  F_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);

        // MTLO, then an op flushed mid-run
        bus.i_lo_we = 1; bus.i_wdata = 32'hCAFE;
        tick();
        clear_req();
        check("mtlo", bus.o_lo, 32'hCAFE);
        present(F_MULTU, 32'd3, 32'd5);
        tick();
        clear_req();
        repeat (10) tick();
        bus.i_flush = 1;
        tick();
        clear_req();
        check("flush_busy", bus.o_busy, 1'b0);
        check("flush_lo",   bus.o_lo,   32'hCAFE);
        repeat (3) tick();

        // Flush together with start in IDLE, and an illegal funct
        present(F_MULT, 32'd2, 32'd2);
        bus.i_flush = 1;
        tick();
        clear_req();
        check("flush_start_busy", bus.o_busy, 1'b0);
        present(6'b100000, 32'd2, 32'd2);
        tick();
        clear_req();
        check("illegal_busy", bus.o_busy, 1'b0);

        // MTHI accepted alongside a start, then overwritten at finish
        present(F_MULTU, 32'd2, 32'd3);
        bus.i_hi_we = 1; bus.i_wdata = 32'h1234;
        tick();
        clear_req();
        check("mthi_start_hi",   bus.o_hi,   32'h1234);
        check("mthi_start_busy", bus.o_busy, 1'b1);
        repeat (N + 1) tick();
        check("mthi_op_hi", bus.o_hi, 32'h0);
        check("mthi_op_lo", bus.o_lo, 32'h6);
        tick();

        // Flush landing in the finish cycle drops the result
        present(F_DIVU, 32'd100, 32'd7);
        tick();
        clear_req();
        repeat (N) tick();
        bus.i_flush = 1;
        tick();
        clear_req();
        check("fin_flush_busy", bus.o_busy, 1'b0);
        check("fin_flush_lo",   bus.o_lo,   32'h6);
        tick();
        check("fin_flush_done", bus.o_done, 1'b0);

        // Requests while busy are ignored; reset mid-run clears everything
        present(F_MULTU, 32'd7, 32'd9);
        tick();
        clear_req();
        repeat (5) tick();
        present(F_DIVU, 32'd1, 32'd1);
        bus.i_hi_we = 1; bus.i_wdata = 32'hDEAD;
        tick();
        clear_req();
        check("busy_mthi_hi",   bus.o_hi,   32'h0);
        check("busy_mthi_busy", bus.o_busy, 1'b1);
        repeat (14) tick();
        rst = 1;
        tick();
        rst = 0;
        check("midrst_busy", bus.o_busy, 1'b0);
        check("midrst_hi",   bus.o_hi,   32'h0);
        check("midrst_lo",   bus.o_lo,   32'h0);
        repeat (3) tick();

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
